// File: rtl/core_bus_arbiter_if.sv
// Cache-bus request/response types and the bundle connecting the two core
// caches and the downstream bridge to core_bus_arbiter.
package core_bus_pkg;
   localparam int BURST_W = 2;

   typedef struct packed {
      logic               valid;
      logic               write;
      logic [31:0]        addr;
      logic [BURST_W-1:0] burst_size;
      logic               data_ok;
      logic               data_last;
      logic [3:0]         data_strobe;
      logic [31:0]        w_data;
   } cache_bus_req_t;

   typedef struct packed {
      logic        ready;
      logic        data_ok;
      logic        data_last;
      logic [31:0] r_data;
   } cache_bus_resp_t;
endpackage

interface core_bus_arbiter_if;
   import core_bus_pkg::*;

   cache_bus_req_t  [1:0] m_req_i;
   cache_bus_resp_t [1:0] m_resp_o;
   logic            [1:0] m_busy_o;
   cache_bus_req_t        bus_req_o;
   cache_bus_resp_t       bus_resp_i;
   logic                  owner_o;
   logic                  active_o;

   modport slave (
      input  m_req_i, bus_resp_i,
      output m_resp_o, m_busy_o, bus_req_o, owner_o, active_o
   );

   modport master (
      output m_req_i, bus_resp_i,
      input  m_resp_o, m_busy_o, bus_req_o, owner_o, active_o
   );
endinterface

// File: rtl/core_bus_arbiter.sv
// Two-master arbiter for the shared cache bus: serialises whole transactions
// (address phase plus every data beat) between icache (0) and dcache (1).
module core_bus_arbiter
   import core_bus_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input logic               clk,
   input logic               rst_n,
   core_bus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ADDR, RDATA, WDATA} state_e;

   state_e             state_q;
   logic               owner_q;
   logic [CNT_W-1:0]   starve_q;
   logic [CNT_W-1:0]   starve_d;
   logic [BURST_W-1:0] beat_q;
   logic [BURST_W-1:0] burst_q;
   logic               win_d;
   logic               m0_v;
   logic               m1_v;
   logic               starved;
   cache_bus_req_t     own_req;

   assign m0_v    = bus.m_req_i[0].valid;
   assign m1_v    = bus.m_req_i[1].valid;
   assign own_req = bus.m_req_i[owner_q];

   // dcache wins by default; icache takes one grant once it has waited out the limit
   assign starved = m0_v && (starve_q == CNT_W'(STARVE_LIMIT));
   assign win_d   = m1_v && !starved;

   always_comb begin
      starve_d = '0;
      if (win_d && m0_v)
         starve_d = starved ? starve_q : starve_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         starve_q <= '0;
         beat_q   <= '0;
         burst_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (m0_v || m1_v) begin
                  owner_q  <= win_d;
                  starve_q <= starve_d;
                  state_q  <= ADDR;
               end
            end
            ADDR: begin
               // an owner withdrawing its request mid-address-phase is simply dropped
               if (!own_req.valid) begin
                  state_q <= IDLE;
               end else if (bus.bus_resp_i.ready) begin
                  burst_q <= own_req.burst_size;
                  beat_q  <= '0;
                  state_q <= own_req.write ? WDATA : RDATA;
               end
            end
            RDATA: begin
               if (bus.bus_resp_i.data_ok) begin
                  beat_q <= beat_q + BURST_W'(1);
                  if (beat_q == burst_q)
                     state_q <= IDLE;
               end
            end
            WDATA: begin
               if (own_req.data_ok && own_req.data_last && bus.bus_resp_i.data_ok)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.bus_req_o = '0;
      bus.m_resp_o  = '0;
      unique case (state_q)
         ADDR: begin
            bus.bus_req_o                = own_req;
            bus.m_resp_o[owner_q].ready  = bus.bus_resp_i.ready;
         end
         RDATA: begin
            bus.bus_req_o.data_ok           = own_req.data_ok;
            bus.m_resp_o[owner_q].data_ok   = bus.bus_resp_i.data_ok;
            bus.m_resp_o[owner_q].data_last = bus.bus_resp_i.data_last;
            bus.m_resp_o[owner_q].r_data    = bus.bus_resp_i.r_data;
         end
         WDATA: begin
            bus.bus_req_o.data_ok         = own_req.data_ok;
            bus.bus_req_o.data_last       = own_req.data_last;
            bus.bus_req_o.data_strobe     = own_req.data_strobe;
            bus.bus_req_o.w_data          = own_req.w_data;
            bus.m_resp_o[owner_q].data_ok = bus.bus_resp_i.data_ok;
         end
         default: ;
      endcase
   end

   // busy depends only on registered state so a master's own request never loops back
   assign bus.m_busy_o = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b01 : 2'b10);
   assign bus.active_o = (state_q != IDLE);
   assign bus.owner_o  = owner_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed plus randomized bench for core_bus_arbiter; grant order is
// predicted from the priority/starvation rule over a request table.
module tb_core_bus_arbiter;
   import core_bus_pkg::*;

   localparam int LIMIT = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad   = 0;

   bit          req_v     [2];
   bit          req_wr    [2];
   int          req_beats [2];
   logic [31:0] req_addr  [2];
   int          cnt_m = 0;
   int          last_own = 0;

   core_bus_arbiter_if intf();

   core_bus_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (intf)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_reqs();
      for (int i = 0; i < 2; i++) begin
         intf.m_req_i[i]            = '0;
         intf.m_req_i[i].valid      = req_v[i];
         intf.m_req_i[i].write      = req_wr[i];
         intf.m_req_i[i].addr       = req_addr[i];
         intf.m_req_i[i].burst_size = BURST_W'(req_beats[i] - 1);
      end
      intf.bus_resp_i = '0;
   endtask

   task automatic set_req(input int m, input bit wr, input int beats, input logic [31:0] addr);
      req_v[m]     = 1'b1;
      req_wr[m]    = wr;
      req_beats[m] = beats;
      req_addr[m]  = addr;
   endtask

   // Reference grant decision: dcache unless icache has waited LIMIT dcache grants.
   function automatic int pick();
      int w;
      w = (req_v[1] && !(req_v[0] && cnt_m == LIMIT)) ? 1 : 0;
      if (w == 1 && req_v[0]) cnt_m = (cnt_m < LIMIT) ? cnt_m + 1 : LIMIT;
      else                    cnt_m = 0;
      last_own = w;
      return w;
   endfunction

   task automatic idle_check(input int own);
      apply_reqs();
      #1;
      check("idle_active", intf.active_o, 0);
      check("idle_busy", intf.m_busy_o, 0);
      check("idle_bus_req", |intf.bus_req_o, 0);
      check("idle_resp", |intf.m_resp_o, 0);
      check("idle_owner", intf.owner_o, own);
   endtask

   task automatic do_txn(input int m, input int rdy_dly, input int dok_dly, input int abort_at);
      int          w;
      bit          wr;
      int          beats;
      int          busy_exp;
      logic [31:0] wd;
      logic [31:0] rd;
      logic [3:0]  st;
      bit          last;
      wr       = req_wr[m];
      beats    = req_beats[m];
      busy_exp = (m == 0) ? 2 : 1;
      w        = 0;
      @(negedge clk); #1;
      while (!intf.bus_req_o.valid && w < 8) begin
         @(negedge clk); #1;
         w++;
      end
      check("grant_latency", w, 0);
      if (w >= 8) return;
      check("owner", intf.owner_o, m);
      check("addr", intf.bus_req_o.addr, req_addr[m]);
      check("write", intf.bus_req_o.write, wr);
      check("burst", intf.bus_req_o.burst_size, beats - 1);
      check("busy_addr", intf.m_busy_o, busy_exp);
      for (int i = 0; i < rdy_dly; i++) begin
         check("ready_hold", intf.m_resp_o[m].ready, 0);
         @(negedge clk); #1;
      end
      intf.bus_resp_i.ready = 1'b1;
      #1;
      check("ready_fwd", intf.m_resp_o[m].ready, 1);
      check("other_resp_addr", |intf.m_resp_o[1-m], 0);
      @(negedge clk);
      req_v[m] = 1'b0;
      apply_reqs();
      for (int b = 0; b < beats; b++) begin
         wd   = $urandom;
         rd   = $urandom;
         st   = 4'($urandom);
         last = (b == beats - 1);
         intf.bus_resp_i = '0;
         intf.m_req_i[m].data_ok = 1'b1;
         if (wr) begin
            intf.m_req_i[m].data_last   = last;
            intf.m_req_i[m].data_strobe = st;
            intf.m_req_i[m].w_data      = wd;
         end
         for (int d = 0; d < dok_dly; d++) begin
            #1;
            check("active_mid", intf.active_o, 1);
            check("busy_mid", intf.m_busy_o, busy_exp);
            check("resp_wait", intf.m_resp_o[m].data_ok, 0);
            if (wr)
               check("wdata_wait", {intf.bus_req_o.data_ok, intf.bus_req_o.data_last,
                                    intf.bus_req_o.data_strobe, intf.bus_req_o.w_data},
                     {1'b1, last, st, wd});
            @(negedge clk);
         end
         if (b == abort_at) begin
            intf.bus_resp_i.data_ok = 1'b1;
            intf.bus_resp_i.r_data  = rd;
            #1;
            check("pre_rst_dok", intf.m_resp_o[m].data_ok, 1);
            rst_n = 1'b0;
            #1;
            check("rst_active", intf.active_o, 0);
            check("rst_busy", intf.m_busy_o, 0);
            check("rst_bus_req", |intf.bus_req_o, 0);
            check("rst_resp", |intf.m_resp_o, 0);
            check("rst_owner", intf.owner_o, 0);
            @(negedge clk); #1;
            check("rst_hold_resp", |intf.m_resp_o, 0);
            @(negedge clk);
            rst_n    = 1'b1;
            cnt_m    = 0;
            last_own = 0;
            req_v[0] = 1'b0;
            req_v[1] = 1'b0;
            apply_reqs();
            return;
         end
         intf.bus_resp_i.data_ok   = 1'b1;
         intf.bus_resp_i.r_data    = rd;
         intf.bus_resp_i.data_last = last;
         #1;
         check("dok_fwd", intf.m_resp_o[m].data_ok, 1);
         check("active_beat", intf.active_o, 1);
         check("busy_beat", intf.m_busy_o, busy_exp);
         check("other_resp_data", |intf.m_resp_o[1-m], 0);
         if (wr) begin
            check("wdata_fwd", {intf.bus_req_o.data_ok, intf.bus_req_o.data_last,
                                intf.bus_req_o.data_strobe, intf.bus_req_o.w_data},
                  {1'b1, last, st, wd});
         end else begin
            check("rdata", intf.m_resp_o[m].r_data, rd);
            check("rlast", intf.m_resp_o[m].data_last, last);
            check("rd_dok_up", intf.bus_req_o.data_ok, 1);
         end
         @(negedge clk);
      end
      apply_reqs();
   endtask

   initial begin
      int w;
      for (int i = 0; i < 2; i++) begin
         req_v[i] = 1'b0; req_wr[i] = 1'b0; req_beats[i] = 1; req_addr[i] = '0;
      end
      apply_reqs();
      #2 rst_n = 1'b0;
      #1;
      check("reset_active", intf.active_o, 0);
      check("reset_busy", intf.m_busy_o, 0);
      check("reset_bus_req", |intf.bus_req_o, 0);
      check("reset_resp", |intf.m_resp_o, 0);
      check("reset_owner", intf.owner_o, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // single icache refill
      set_req(0, 1'b0, 4, 32'h0000_1000);
      idle_check(last_own);
      do_txn(pick(), 2, 0, -1);
      idle_check(last_own);

      // contention: dcache first, icache right after
      set_req(0, 1'b0, 1, 32'h0000_2000);
      set_req(1, 1'b0, 2, 32'h0000_3000);
      idle_check(last_own);
      do_txn(pick(), 1, 1, -1);
      idle_check(last_own);
      do_txn(pick(), 0, 0, -1);
      idle_check(last_own);

      // starvation: icache held while dcache reissues
      set_req(0, 1'b0, 1, 32'h0000_4000);
      for (int g = 0; g < 6; g++) begin
         set_req(1, 1'b0, 1, 32'h0000_5000 + 32'(g * 4));
         idle_check(last_own);
         do_txn(pick(), 0, 0, -1);
      end
      set_req(0, 1'b0, 1, 32'h0000_4100);
      set_req(1, 1'b0, 1, 32'h0000_5100);
      idle_check(last_own);
      do_txn(pick(), 0, 0, -1);
      idle_check(last_own);
      do_txn(pick(), 0, 0, -1);
      idle_check(last_own);

      // dcache 4-beat write with a slow bus
      set_req(1, 1'b1, 4, 32'h0000_6000);
      idle_check(last_own);
      do_txn(pick(), 1, 1, -1);
      idle_check(last_own);

      // uncached fetch pair
      set_req(0, 1'b0, 1, 32'h0000_7000);
      idle_check(last_own);
      do_txn(pick(), 0, 0, -1);
      set_req(0, 1'b0, 1, 32'h0000_7004);
      idle_check(last_own);
      do_txn(pick(), 0, 0, -1);
      idle_check(last_own);

      // reset in the middle of a dcache line read, then a fresh request
      set_req(1, 1'b0, 4, 32'h0000_8000);
      idle_check(last_own);
      do_txn(pick(), 0, 0, 2);
      set_req(1, 1'b0, 1, 32'h0000_9000);
      idle_check(0);
      do_txn(pick(), 0, 0, -1);
      idle_check(last_own);

      // randomized mix
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 2; i++)
            if (!req_v[i] && $urandom_range(0, 1) == 1)
               set_req(i, 1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom & 32'hFFFF_FFF0);
         if (!req_v[0] && !req_v[1]) begin
            w = $urandom_range(0, 1);
            set_req(w, 1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom & 32'hFFFF_FFF0);
         end
         idle_check(last_own);
         do_txn(pick(), $urandom_range(0, 2), $urandom_range(0, 2), -1);
      end
      idle_check(last_own);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
